// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: decode opcodes plus branch target buffer entry/counter types.
package cpu_types_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } btb_cnt_t;

    // Tag field is sized for the smallest legal table (2 entries); narrower tags are zero-extended.
    localparam int unsigned BTB_TAG_W = 29;
    localparam int unsigned BTB_TGT_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        btb_cnt_t             cnt;
    } btb_entry_t;

    localparam btb_cnt_t BTB_CNT_RESET = WNT;

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating counter next-state function for the branch target buffer.
module btb_sat_counter
    import cpu_types_pkg::*;
(
    input  btb_cnt_t i_cnt,
    input  logic     i_taken,
    output btb_cnt_t o_cnt_next
);

    always_comb begin
        o_cnt_next = i_cnt;
        case (i_cnt)
            SNT:     o_cnt_next = i_taken ? WNT : SNT;
            WNT:     o_cnt_next = i_taken ? WT  : SNT;
            WT:      o_cnt_next = i_taken ? ST  : WNT;
            ST:      o_cnt_next = i_taken ? ST  : WT;
            default: o_cnt_next = i_cnt;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters, zero-latency prediction and mispredict detect.
// Optional statistics counters enabled by defining BTB_STATS_EN.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts,
    output logic [31:0] stat_allocs
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0]     w_fetch_idx;
    logic [IDX_W-1:0]     w_res_idx;
    logic [BTB_TAG_W-1:0] w_fetch_tag;
    logic [BTB_TAG_W-1:0] w_res_tag;
    btb_entry_t           w_fetch_entry;
    btb_entry_t           w_res_entry;
    logic                 w_fetch_hit;
    logic                 w_res_hit;
    logic                 w_alloc;
    btb_cnt_t             w_cnt_next;

    assign w_fetch_idx   = IDX_W'(fetch_pc >> 2);
    assign w_res_idx     = IDX_W'(resolve_pc >> 2);
    assign w_fetch_tag   = BTB_TAG_W'(fetch_pc >> (IDX_W + 2));
    assign w_res_tag     = BTB_TAG_W'(resolve_pc >> (IDX_W + 2));
    assign w_fetch_entry = r_table[w_fetch_idx];
    assign w_res_entry   = r_table[w_res_idx];
    assign w_fetch_hit   = w_fetch_entry.valid && (w_fetch_entry.tag == w_fetch_tag);
    assign w_res_hit     = w_res_entry.valid && (w_res_entry.tag == w_res_tag);
    assign w_alloc       = resolve_valid && !w_res_hit && resolve_taken;

    btb_sat_counter u_sat (
        .i_cnt      (w_res_entry.cnt),
        .i_taken    (resolve_taken),
        .o_cnt_next (w_cnt_next)
    );

    // Prediction reads pre-update table state; no bypass from the update port.
    always_comb begin
        pred_taken  = w_fetch_hit && w_fetch_entry.cnt[1];
        pred_target = fetch_pc + 32'd4;
        if (pred_taken) begin
            pred_target = {w_fetch_entry.target, 2'b00};
        end
    end

    always_comb begin
        mispredict  = resolve_valid &&
                      ((resolve_taken != resolve_pred_taken) ||
                       (resolve_taken && (resolve_pred_target != resolve_target)));
        redirect_pc = 32'd0;
        if (mispredict) begin
            redirect_pc = resolve_taken ? resolve_target : (resolve_pc + 32'd4);
        end
    end

    // Reset wins over a same-cycle resolve; not-taken misses leave the table untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[IDX_W'(i)] <= '{valid: 1'b0, tag: '0, target: '0, cnt: BTB_CNT_RESET};
            end
        end else if (resolve_valid) begin
            if (w_res_hit) begin
                r_table[w_res_idx].cnt <= w_cnt_next;
                if (resolve_taken) begin
                    r_table[w_res_idx].target <= resolve_target[31:2];
                end
            end else if (resolve_taken) begin
                r_table[w_res_idx] <= '{valid: 1'b1, tag: w_res_tag,
                                        target: resolve_target[31:2], cnt: WT};
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_mispredicts;
    logic [31:0] r_stat_allocs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_lookups     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
            r_stat_allocs      <= 32'd0;
        end else begin
            if (resolve_valid) r_stat_lookups     <= r_stat_lookups + 32'd1;
            if (mispredict)    r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            if (w_alloc)       r_stat_allocs      <= r_stat_allocs + 32'd1;
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_mispredicts = r_stat_mispredicts;
    assign stat_allocs      = r_stat_allocs;
`else
    logic w_alloc_unused;
    assign w_alloc_unused = w_alloc;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (16 entries); stats checks when BTB_STATS_EN is defined.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
    logic [31:0] stat_allocs;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .CLK                 (clk),
        .RST                 (rst),
        .fetch_pc            (fetch_pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .mispredict          (mispredict),
        .redirect_pc         (redirect_pc)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups        (stat_lookups),
        .stat_mispredicts    (stat_mispredicts),
        .stat_allocs         (stat_allocs)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        resolve_valid       = 1'b1;
        resolve_pc          = pc;
        resolve_taken       = tk;
        resolve_target      = tgt;
        resolve_pred_taken  = ptk;
        resolve_pred_target = ptgt;
    endtask

    task automatic idle();
        resolve_valid       = 1'b0;
        resolve_pc          = 'x;
        resolve_taken       = 1'bx;
        resolve_target      = 'x;
        resolve_pred_taken  = 1'bx;
        resolve_pred_target = 'x;
    endtask

    task automatic pred(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        chk({tag, "_taken"},  32'(pred_taken), 32'(exp_tk));
        chk({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 32'h0000_0040;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        pred("rst_0x40", 32'h40, 1'b0, 32'h44);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
`ifdef BTB_STATS_EN
        chk("stat_lookups_rst", stat_lookups, 32'd0);
        chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
        chk("stat_allocs_rst", stat_allocs, 32'd0);
`endif

        // First taken resolve allocates; same-cycle fetch sees pre-update state
        res(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        pred("alloc_same_cycle", 32'h40, 1'b0, 32'h44);
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h100);
        tick();
        idle();
        pred("alloc_next", 32'h40, 1'b1, 32'h100);
`ifdef BTB_STATS_EN
        chk("stat_lookups_1", stat_lookups, 32'd1);
        chk("stat_mispredicts_1", stat_mispredicts, 32'd1);
        chk("stat_allocs_1", stat_allocs, 32'd1);
`endif

        // Two more taken resolves: WT->ST->ST, correctly predicted
        res(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        #1;
        chk("taken_ok_mispredict", 32'(mispredict), 32'd0);
        chk("taken_ok_redirect", redirect_pc, 32'd0);
        tick();
        tick();
        // Not-taken from ST: mispredict to pc+4, target kept, still predicted taken (ST->WT)
        res(32'h40, 1'b0, 32'h300, 1'b1, 32'h100);
        #1;
        chk("nt1_mispredict", 32'(mispredict), 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h44);
        tick();
        idle();
        pred("after_nt1", 32'h40, 1'b1, 32'h100);
        // WT->WNT: now predicted not-taken
        res(32'h40, 1'b0, 32'h300, 1'b1, 32'h100);
        tick();
        idle();
        pred("after_nt2", 32'h40, 1'b0, 32'h44);
        // WNT->SNT->SNT, then one taken -> WNT (still not-taken), another -> WT
        res(32'h40, 1'b0, 32'h300, 1'b0, 32'h0);
        #1;
        chk("nt_ok_mispredict", 32'(mispredict), 32'd0);
        tick();
        tick();
        res(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        pred("sat_low_t1", 32'h40, 1'b0, 32'h44);
        res(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        pred("sat_low_t2", 32'h40, 1'b1, 32'h100);

        // Aliasing: 0x440 shares index 0 with 0x40 and replaces it
        res(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        idle();
        pred("alias_0x40", 32'h40, 1'b0, 32'h44);
        pred("alias_0x440", 32'h440, 1'b1, 32'h200);

        // Same-cycle fetch/resolve at 0x80 (also index 0)
        res(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
        pred("same_0x80", 32'h80, 1'b0, 32'h84);
        tick();
        idle();
        pred("next_0x80", 32'h80, 1'b1, 32'h100);
        // Direction right, target wrong
        res(32'h80, 1'b1, 32'h180, 1'b1, 32'h100);
        #1;
        chk("tgt_mispredict", 32'(mispredict), 32'd1);
        chk("tgt_redirect", redirect_pc, 32'h180);
        tick();
        idle();
        pred("tgt_updated", 32'h80, 1'b1, 32'h180);

        // Idle with X on resolve inputs: no mispredict, no state change; fetch+4 wraps
        #1;
        chk("idle_mispredict", 32'(mispredict), 32'd0);
        chk("idle_redirect", redirect_pc, 32'd0);
        tick();
        pred("idle_0x80", 32'h80, 1'b1, 32'h180);
        pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Reset with a concurrent taken resolve: dropped, table wiped
        rst = 1'b1;
        res(32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        pred("in_rst_0x80", 32'h80, 1'b0, 32'h84);
        rst = 1'b0;
        idle();
        tick();
        pred("post_rst_0x80", 32'h80, 1'b0, 32'h84);
        pred("post_rst_0x500", 32'h500, 1'b0, 32'h504);
        pred("post_rst_0x440", 32'h440, 1'b0, 32'h444);
`ifdef BTB_STATS_EN
        chk("stat_lookups_rst2", stat_lookups, 32'd0);
        chk("stat_mispredicts_rst2", stat_mispredicts, 32'd0);
        chk("stat_allocs_rst2", stat_allocs, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
